// File: rtl/przyciski_kondycjonowanie_if.sv
// Button-conditioning bus: raw button inputs towards the conditioner and the
// conditioned vector, press/hold/start-stop indications back to the consumer.
interface przyciski_kondycjonowanie_if;
  logic [3:0] i_Przyciski;
  logic       i_Przycisk_odliczanie;
  logic [3:0] o_Przyciski_stan;
  logic       o_Przyciski_impuls;
  logic       o_Przyciski_przytrzymanie;
  logic       o_Przycisk_odliczanie_impuls;

  modport master (
    output i_Przyciski,
    output i_Przycisk_odliczanie,
    input  o_Przyciski_stan,
    input  o_Przyciski_impuls,
    input  o_Przyciski_przytrzymanie,
    input  o_Przycisk_odliczanie_impuls
  );

  modport slave (
    input  i_Przyciski,
    input  i_Przycisk_odliczanie,
    output o_Przyciski_stan,
    output o_Przyciski_impuls,
    output o_Przyciski_przytrzymanie,
    output o_Przycisk_odliczanie_impuls
  );
endinterface

// File: rtl/przyciski_kondycjonowanie.sv
// Kitchen-timer button conditioning: sync, debounce, press impulse, long-press hold.
// Optional PRZYCISKI_BLOKADA_START_EN blocks the start/stop impulse while any button is down.
module przyciski_kondycjonowanie #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 500
) (
  input logic                        i_CLK,
  input logic                        i_Reset,
  przyciski_kondycjonowanie_if.slave bus
);
  localparam int unsigned DebRaw         = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DebounceCycles = (DebRaw < 1) ? 1 : DebRaw;
  localparam int unsigned HoldRaw        = CLK_HZ / 1000 * HOLD_MS;
  localparam int unsigned HoldCycles     = (HoldRaw < 1) ? 1 : HoldRaw;
  localparam int unsigned DebW           = $clog2(DebounceCycles + 1);
  localparam int unsigned HoldW          = $clog2(HoldCycles + 1);
  localparam logic [DebW-1:0]  DebMax    = DebW'(DebounceCycles);
  localparam logic [HoldW-1:0] HoldMax   = HoldW'(HoldCycles);

  typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

  logic [4:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]      stan_q, stan_d, vec_cand_q, vec_cand_d;
  logic [DebW-1:0] vec_cnt_q, vec_cnt_d;
  logic            vec_commit;
  logic            ss_stan_q, ss_stan_d, ss_cand_q, ss_cand_d;
  logic [DebW-1:0] ss_cnt_q, ss_cnt_d;
  logic            ss_commit;
  logic            vec_imp_q, vec_imp_d, ss_imp_q, ss_imp_d;
  state_e          state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]      vec_sample;
  logic            ss_sample;

  assign sync1_d    = {bus.i_Przycisk_odliczanie, bus.i_Przyciski};
  assign sync2_d    = sync1_q;
  assign vec_sample = sync2_q[3:0];
  assign ss_sample  = sync2_q[4];

  // Vector debouncer: the whole 4-bit word must be stable, so combinations debounce as one.
  always_comb begin
    stan_d     = stan_q;
    vec_cand_d = vec_cand_q;
    vec_cnt_d  = vec_cnt_q;
    vec_commit = 1'b0;
    if (vec_sample == stan_q) begin
      vec_cnt_d = '0;
    end else if (vec_sample == vec_cand_q) begin
      if (vec_cnt_q == DebMax - 1'b1) begin
        stan_d     = vec_cand_q;
        vec_cnt_d  = '0;
        vec_commit = 1'b1;
      end else begin
        vec_cnt_d = vec_cnt_q + 1'b1;
      end
    end else begin
      vec_cand_d = vec_sample;
      if (DebounceCycles == 1) begin
        stan_d     = vec_sample;
        vec_cnt_d  = '0;
        vec_commit = 1'b1;
      end else begin
        vec_cnt_d = DebW'(1);
      end
    end
  end

  always_comb begin
    ss_stan_d = ss_stan_q;
    ss_cand_d = ss_cand_q;
    ss_cnt_d  = ss_cnt_q;
    ss_commit = 1'b0;
    if (ss_sample == ss_stan_q) begin
      ss_cnt_d = '0;
    end else if (ss_sample == ss_cand_q) begin
      if (ss_cnt_q == DebMax - 1'b1) begin
        ss_stan_d = ss_cand_q;
        ss_cnt_d  = '0;
        ss_commit = 1'b1;
      end else begin
        ss_cnt_d = ss_cnt_q + 1'b1;
      end
    end else begin
      ss_cand_d = ss_sample;
      if (DebounceCycles == 1) begin
        ss_stan_d = ss_sample;
        ss_cnt_d  = '0;
        ss_commit = 1'b1;
      end else begin
        ss_cnt_d = DebW'(1);
      end
    end
  end

  // Impulses are registered alongside stan so they appear in the first cycle of the new value.
  always_comb begin
    vec_imp_d = vec_commit && (stan_d != 4'b0000);
`ifdef PRZYCISKI_BLOKADA_START_EN
    ss_imp_d  = ss_commit && ss_stan_d && (stan_d == 4'b0000);
`else
    ss_imp_d  = ss_commit && ss_stan_d;
`endif
  end

  // A stan change always wins over hold expiry, keeping impulse and hold exclusive.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (vec_commit && (stan_d != 4'b0000)) begin
          state_d    = StPressed;
          hold_cnt_d = '0;
        end
      end
      StPressed: begin
        if (vec_commit) begin
          state_d    = (stan_d == 4'b0000) ? StIdle : StPressed;
          hold_cnt_d = '0;
        end else if (hold_cnt_q >= HoldMax - 1'b1) begin
          state_d    = StHeld;
          hold_cnt_d = HoldMax;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (vec_commit) begin
          state_d    = (stan_d == 4'b0000) ? StIdle : StPressed;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stan_q     <= '0;
      vec_cand_q <= '0;
      vec_cnt_q  <= '0;
      ss_stan_q  <= 1'b0;
      ss_cand_q  <= 1'b0;
      ss_cnt_q   <= '0;
      vec_imp_q  <= 1'b0;
      ss_imp_q   <= 1'b0;
      state_q    <= StIdle;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stan_q     <= stan_d;
      vec_cand_q <= vec_cand_d;
      vec_cnt_q  <= vec_cnt_d;
      ss_stan_q  <= ss_stan_d;
      ss_cand_q  <= ss_cand_d;
      ss_cnt_q   <= ss_cnt_d;
      vec_imp_q  <= vec_imp_d;
      ss_imp_q   <= ss_imp_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.o_Przyciski_stan             = stan_q;
  assign bus.o_Przyciski_impuls           = vec_imp_q;
  assign bus.o_Przyciski_przytrzymanie    = (state_q == StHeld);
  assign bus.o_Przycisk_odliczanie_impuls = ss_imp_q;
endmodule
